// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, the reset fetch
// address, the fetch FSM state encoding and small address helpers.
package fetch_stage_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ENTRY_W = INSTR_W + XLEN;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// redirect input and the decode-facing instruction output.
interface fetch_stage_if;

   logic                                 imem_req_valid;
   logic [fetch_stage_pkg::XLEN-1:0]     imem_req_addr;
   logic                                 imem_req_ready;
   logic                                 imem_resp_valid;
   logic [fetch_stage_pkg::INSTR_W-1:0]  imem_resp_data;
   logic                                 stall;
   logic                                 br_taken;
   logic [fetch_stage_pkg::XLEN-1:0]     br_target;
   logic                                 if_valid;
   logic [fetch_stage_pkg::INSTR_W-1:0]  if_instr;
   logic [fetch_stage_pkg::XLEN-1:0]     if_next_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  stall, br_taken, br_target,
      output if_valid, if_instr, if_next_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output stall, br_taken, br_target,
      input  if_valid, if_instr, if_next_pc
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO holding {instruction, next_pc} entries between instruction
// memory and decode. Flush empties it; push and pop may share a cycle.
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_push_data,
   input  logic               i_pop,
   input  logic               i_flush,
   output logic [ENTRY_W-1:0] o_head,
   output logic [CNT_W-1:0]   o_count,
   output logic               o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_pop;
   logic               w_do_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   assign w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
   // a full buffer only accepts a push when the head leaves in the same cycle
   assign w_do_push = i_push && ((r_count < CNT_W'(DEPTH)) || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= {ENTRY_W{1'b0}};
         end
      end else if (i_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited sequential requests to instruction
// memory, in-order response buffering and branch redirect with drain.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     MAX_OUT  = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master io_fetch
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e       r_state;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_resp_pc;
   logic [CNT_W-1:0]   r_outstanding;

   logic [CNT_W-1:0]   w_buf_count;
   logic               w_buf_empty;
   logic [ENTRY_W-1:0] w_head;
   logic [ENTRY_W-1:0] w_push_data;
   logic [SUM_W-1:0]   w_in_use;
   logic               w_credit_ok;
   logic               w_req_valid;
   logic               w_accept;
   logic               w_resp;
   logic               w_discard;
   logic               w_push;
   logic               w_if_valid;
   logic               w_pop;
   logic [CNT_W-1:0]   w_out_next;
   logic [XLEN-1:0]    w_redirect_pc;

   assign w_in_use    = {1'b0, r_outstanding} + {1'b0, w_buf_count};
   assign w_credit_ok = (w_in_use < SUM_W'(MAX_OUT));
   assign w_req_valid = !rst && (r_state == ST_RUN) && w_credit_ok && !io_fetch.br_taken;
   assign w_accept    = w_req_valid && io_fetch.imem_req_ready;

   // responses are only counted against requests we actually issued
   assign w_resp      = io_fetch.imem_resp_valid && (r_outstanding != {CNT_W{1'b0}});
   assign w_discard   = io_fetch.br_taken || (r_state != ST_RUN);
   assign w_push      = w_resp && !w_discard;
   assign w_push_data = {io_fetch.imem_resp_data, pc_plus4(r_resp_pc)};

   assign w_if_valid  = !rst && !w_buf_empty && !io_fetch.br_taken;
   assign w_pop       = w_if_valid && !io_fetch.stall;

   assign w_out_next    = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);
   assign w_redirect_pc = word_align(io_fetch.br_target);

   fetch_buffer #(
      .DEPTH (MAX_OUT)
   ) u_buffer (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_flush     (io_fetch.br_taken),
      .o_head      (w_head),
      .o_count     (w_buf_count),
      .o_empty     (w_buf_empty)
   );

   // r_resp_pc tracks the address of the oldest response that will be kept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= {CNT_W{1'b0}};
      end else begin
         r_outstanding <= w_out_next;
         if (io_fetch.br_taken) begin
            r_pc      <= w_redirect_pc;
            r_resp_pc <= w_redirect_pc;
            if ((r_state == ST_DRAIN) || (w_out_next != {CNT_W{1'b0}})) begin
               r_state <= ST_DRAIN;
            end else begin
               r_state <= ST_RUN;
            end
         end else begin
            if (w_accept) begin
               r_pc <= pc_plus4(r_pc);
            end
            if (w_push) begin
               r_resp_pc <= pc_plus4(r_resp_pc);
            end
            case (r_state)
               ST_BOOT:  r_state <= ST_RUN;
               ST_RUN:   r_state <= ST_RUN;
               ST_DRAIN: r_state <= (w_out_next == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
               default:  r_state <= ST_BOOT;
            endcase
         end
      end
   end

   assign io_fetch.imem_req_valid = w_req_valid;
   assign io_fetch.imem_req_addr  = r_pc;
   assign io_fetch.if_valid       = w_if_valid;
   assign io_fetch.if_instr       = w_head[ENTRY_W-1:XLEN];
   assign io_fetch.if_next_pc     = w_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: per-cycle inputs with
// hand-computed outputs, plus a hand-written memory-latency sequence.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .MAX_OUT  (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .io_fetch (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        e_rv;
      logic [31:0] e_ra;
      logic        e_iv;
      logic        cd;
      logic [31:0] e_ii;
      logic [31:0] e_np;
   } vec_t;

   localparam int N = 40;
   vec_t vecs [N];

   function automatic vec_t mk(input logic [31:0] r, input logic [31:0] rdy,
                               input logic [31:0] rv, input logic [31:0] rd,
                               input logic [31:0] st, input logic [31:0] br,
                               input logic [31:0] bt, input logic [31:0] erv,
                               input logic [31:0] era, input logic [31:0] eiv,
                               input logic [31:0] cd, input logic [31:0] eii,
                               input logic [31:0] enp);
      vec_t v;
      v.rst = r[0];   v.rdy = rdy[0]; v.rv = rv[0];   v.rd = rd;
      v.stall = st[0]; v.br = br[0];  v.bt = bt;
      v.e_rv = erv[0]; v.e_ra = era;  v.e_iv = eiv[0]; v.cd = cd[0];
      v.e_ii = eii;   v.e_np = enp;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.stall           = 1'b0;
      bus.br_taken        = 1'b0;
      bus.br_target       = 32'h0;
   endtask

   logic found;

   initial begin
      //            rst rdy rv rdata          st br target        | rv ra            iv cd instr          next_pc
      vecs[0]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 1, 32'h0,         32'h0);
      vecs[1]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 1, 32'h0,         32'h0);
      vecs[2]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,        0, 0, 32'h0,         32'h0);
      vecs[3]  = mk(0, 1, 1, 32'hD000_0000,  0, 0, 32'h0,          1, 32'h4,        0, 0, 32'h0,         32'h0);
      vecs[4]  = mk(0, 1, 1, 32'hD000_0004,  0, 0, 32'h0,          0, 32'h8,        1, 1, 32'hD000_0000, 32'h4);
      vecs[5]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,        1, 1, 32'hD000_0004, 32'h8);
      vecs[6]  = mk(0, 1, 1, 32'hD000_0008,  0, 0, 32'h0,          1, 32'hC,        0, 0, 32'h0,         32'h0);
      vecs[7]  = mk(0, 1, 1, 32'hD000_000C,  0, 0, 32'h0,          0, 32'h10,       1, 1, 32'hD000_0008, 32'hC);
      vecs[8]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h10,       1, 1, 32'hD000_000C, 32'h10);
      vecs[9]  = mk(0, 1, 1, 32'hD000_0010,  1, 0, 32'h0,          0, 32'h14,       1, 1, 32'hD000_000C, 32'h10);
      vecs[10] = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h14,       1, 1, 32'hD000_000C, 32'h10);
      vecs[11] = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h14,       1, 1, 32'hD000_000C, 32'h10);
      vecs[12] = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h14,       1, 1, 32'hD000_000C, 32'h10);
      vecs[13] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h14,       1, 1, 32'hD000_000C, 32'h10);
      vecs[14] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h14,       1, 1, 32'hD000_0010, 32'h14);
      vecs[15] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h18,       0, 0, 32'h0,         32'h0);
      vecs[16] = mk(0, 1, 0, 32'h0,          0, 1, 32'h103,        0, 32'h1C,       0, 0, 32'h0,         32'h0);
      vecs[17] = mk(0, 1, 1, 32'hD000_0014,  0, 0, 32'h0,          0, 32'h100,      0, 0, 32'h0,         32'h0);
      vecs[18] = mk(0, 1, 1, 32'hD000_0018,  0, 0, 32'h0,          0, 32'h100,      0, 0, 32'h0,         32'h0);
      vecs[19] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h100,      0, 0, 32'h0,         32'h0);
      vecs[20] = mk(0, 1, 1, 32'hD000_0100,  0, 0, 32'h0,          1, 32'h104,      0, 0, 32'h0,         32'h0);
      vecs[21] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h108,      1, 1, 32'hD000_0100, 32'h104);
      vecs[22] = mk(0, 0, 1, 32'hD000_0104,  0, 0, 32'h0,          1, 32'h108,      0, 0, 32'h0,         32'h0);
      vecs[23] = mk(0, 0, 0, 32'h0,          0, 1, 32'h200,        0, 32'h108,      0, 0, 32'h0,         32'h0);
      vecs[24] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h200,      0, 0, 32'h0,         32'h0);
      vecs[25] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h200,      0, 0, 32'h0,         32'h0);
      vecs[26] = mk(0, 1, 1, 32'hD000_0200,  0, 0, 32'h0,          1, 32'h204,      0, 0, 32'h0,         32'h0);
      vecs[27] = mk(0, 1, 1, 32'hD000_0204,  0, 0, 32'h0,          0, 32'h208,      1, 1, 32'hD000_0200, 32'h204);
      vecs[28] = mk(0, 1, 0, 32'h0,          0, 1, 32'hFFFF_FFFC,  0, 32'h208,      0, 0, 32'h0,         32'h0);
      vecs[29] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC,0, 0, 32'h0,         32'h0);
      vecs[30] = mk(0, 1, 1, 32'hE000_FFFC,  0, 0, 32'h0,          1, 32'h0,        0, 0, 32'h0,         32'h0);
      vecs[31] = mk(0, 1, 1, 32'hE000_0000,  0, 0, 32'h0,          0, 32'h4,        1, 1, 32'hE000_FFFC, 32'h0);
      vecs[32] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,        1, 1, 32'hE000_0000, 32'h4);
      vecs[33] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,        0, 0, 32'h0,         32'h0);
      vecs[34] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,        0, 0, 32'h0,         32'h0);
      vecs[35] = mk(0, 1, 1, 32'hE000_0004,  0, 1, 32'h300,        0, 32'hC,        0, 0, 32'h0,         32'h0);
      vecs[36] = mk(0, 1, 0, 32'h0,          0, 1, 32'h400,        0, 32'h300,      0, 0, 32'h0,         32'h0);
      vecs[37] = mk(1, 1, 0, 32'h0,          0, 1, 32'h500,        0, 32'h400,      0, 0, 32'h0,         32'h0);
      vecs[38] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 1, 32'h0,         32'h0);
      vecs[39] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,        0, 0, 32'h0,         32'h0);

      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         rst                 = vecs[i].rst;
         bus.imem_req_ready  = vecs[i].rdy;
         bus.imem_resp_valid = vecs[i].rv;
         bus.imem_resp_data  = vecs[i].rd;
         bus.stall           = vecs[i].stall;
         bus.br_taken        = vecs[i].br;
         bus.br_target       = vecs[i].bt;
         #1;
         chk("req_valid", i, {31'b0, bus.imem_req_valid}, {31'b0, vecs[i].e_rv});
         chk("req_addr",  i, bus.imem_req_addr,           vecs[i].e_ra);
         chk("if_valid",  i, {31'b0, bus.if_valid},       {31'b0, vecs[i].e_iv});
         if (vecs[i].cd) begin
            chk("if_instr",   i, bus.if_instr,   vecs[i].e_ii);
            chk("if_next_pc", i, bus.if_next_pc, vecs[i].e_np);
         end
      end

      // request-to-if_valid latency with a two-cycle memory
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (bus.imem_req_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("req_wait", 100, {31'b0, found}, 32'h1);
      if (found) begin
         chk("lat_addr", 100, bus.imem_req_addr, 32'h0);
         bus.imem_req_ready = 1'b1;
         @(negedge clk);
         bus.imem_req_ready = 1'b0;
         #1;
         chk("lat_if_valid_t1", 101, {31'b0, bus.if_valid}, 32'h0);
         @(negedge clk);
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = 32'hCAFE_0000;
         #1;
         chk("lat_if_valid_t2", 102, {31'b0, bus.if_valid}, 32'h0);
         @(negedge clk);
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = 32'h0;
         #1;
         chk("lat_if_valid_t3", 103, {31'b0, bus.if_valid}, 32'h1);
         chk("lat_if_instr",    103, bus.if_instr,   32'hCAFE_0000);
         chk("lat_if_next_pc",  103, bus.if_next_pc, 32'h4);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
